// File: rtl/mult_wide_iter.sv
// Digit-serial wide multiplier / multiply-accumulate with valid/ready on both sides.
// One A_W x DIGIT_W partial product is shifted and added into the accumulator per cycle.
module mult_wide_iter #(
  parameter int A_W     = 149,
  parameter int B_W     = 64,
  parameter int DIGIT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic                 in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   p,
  output logic                 busy
);
  localparam int NDIG  = B_W / DIGIT_W;
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((B_W % DIGIT_W) != 0) begin : g_bad_digit
      $error("mult_wide_iter: B_W must be a multiple of DIGIT_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  st, nxt;
  logic [A_W-1:0]          a_r;
  logic [B_W-1:0]          b_r;
  logic [CNT_W-1:0]        k;
  logic [P_W-1:0]          acc, acc_nxt, p_r, p_last, seed, pp_sh;
  logic [DIGIT_W-1:0]      digit;
  logic [A_W+DIGIT_W-1:0]  pp;
  logic                    last_dig, accept;

  assign last_dig = (k == CNT_W'(NDIG - 1));
  assign digit    = b_r[int'(k)*DIGIT_W +: DIGIT_W];
  assign pp       = {{DIGIT_W{1'b0}}, a_r} * {{A_W{1'b0}}, digit};
  assign pp_sh    = P_W'(pp) << (int'(k) * DIGIT_W);
  assign acc_nxt  = acc + pp_sh;
  assign accept   = in_valid && in_ready;

  // An accept in DONE is also the output handshake, so chain off the result being drained.
  assign seed = (st == S_DONE) ? p_r : p_last;

  assign out_valid = (st == S_DONE);
  assign busy      = (st == S_BUSY);
  assign p         = p_r;

  always_comb begin
    nxt      = st;
    in_ready = 1'b0;
    unique case (st)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = S_BUSY;
      end
      S_BUSY: if (last_dig) nxt = S_DONE;
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) nxt = in_valid ? S_BUSY : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      k      <= '0;
      acc    <= '0;
      p_r    <= '0;
      p_last <= '0;
    end else begin
      if (accept) begin
        a_r <= a;
        b_r <= b;
        k   <= '0;
        acc <= in_acc ? seed : '0;
      end else if (st == S_BUSY) begin
        acc <= acc_nxt;
        k   <= k + CNT_W'(1);
        if (last_dig) p_r <= acc_nxt;
      end
      if (st == S_DONE && out_ready) p_last <= p_r;
    end
  end
endmodule

// File: tb/tb_mult_wide_iter.sv
// Randomised self-checking bench: default instance plus an NDIG=3 variant,
// both checked against a plain-arithmetic multiply-accumulate model.
module tb_mult_wide_iter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_acc, out_valid, out_ready, busy;
  logic [148:0] a;
  logic [63:0]  b;
  logic [212:0] p;

  logic         v_in_valid, v_in_ready, v_in_acc, v_out_valid, v_out_ready, v_busy;
  logic [19:0]  v_a;
  logic [47:0]  v_b;
  logic [67:0]  v_p;

  mult_wide_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_acc(in_acc), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy));

  mult_wide_iter #(.A_W(20), .B_W(48), .DIGIT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready), .a(v_a), .b(v_b),
    .in_acc(v_in_acc), .out_valid(v_out_valid), .out_ready(v_out_ready), .p(v_p), .busy(v_busy));

  int n_chk = 0;
  int n_err = 0;
  logic [212:0] plast;   // model of last delivered result, default instance
  logic [67:0]  plast3;  // same, variant instance

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [148:0] rnd_a();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[148:0];
  endfunction

  function automatic logic [63:0] rnd_b();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_ov(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  // Full transaction on the default instance; caller sits #1 after a clock edge.
  task automatic do_op(input string tag, input logic [148:0] ai, input logic [63:0] bi,
                       input logic acc);
    logic [212:0] e;
    int cyc;
    e = {64'b0, ai} * {149'b0, bi};
    if (acc) e = e + plast;
    a = ai; b = bi; in_acc = acc; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = rnd_a(); b = rnd_b(); in_acc = ~acc;
    wait_ov(cyc);
    chk({tag, "_lat"}, 256'(cyc), 256'(2));
    chk(tag, 256'(p), 256'(e));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    plast = e;
    chk({tag, "_drained"}, 256'(out_valid), 256'(0));
  endtask

  initial begin
    logic [212:0] e, pv;
    logic [67:0]  exp3 [4];
    logic [19:0]  sa [4];
    logic [47:0]  sb [4];
    logic         sc [4];
    int cyc, r, di, last_cyc;
    logic prev_ov;

    rst_n = 1'b0; in_valid = 0; in_acc = 0; out_ready = 0; a = '0; b = '0;
    v_in_valid = 0; v_in_acc = 0; v_out_ready = 0; v_a = '0; v_b = '0;
    plast = '0; plast3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_p", 256'(p), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("basic", 149'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    do_op("max", '1, '1, 1'b0);
    e = ~213'd0 - (213'd1 << 149) - (213'd1 << 64) + 213'd2;
    chk("max_formula", 256'(p), 256'(e));
    do_op("acc0", 149'd3, 64'd5, 1'b0);
    chk("acc0_val", 256'(p), 256'(15));
    do_op("acc1", 149'd2, 64'd4, 1'b1);
    chk("acc1_val", 256'(p), 256'(23));
    do_op("acc2", 149'd0, 64'd0, 1'b1);
    chk("acc2_val", 256'(p), 256'(23));
    for (int i = 0; i < 12; i++) do_op("rand", rnd_a(), rnd_b(), 1'($urandom_range(0, 1)));

    // back-pressure with a pending request
    a = 149'd1000; b = 64'd77; in_acc = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 149'd11; b = 64'd13; in_acc = 1'b1;
    wait_ov(cyc);
    pv = p;
    chk("bp_first", 256'(pv), 256'(77000));
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 256'(in_ready), 256'(0));
      @(posedge clk); #1;
      chk("bp_p_stable", 256'(p), 256'(pv));
      chk("bp_not_taken", 256'({busy, out_valid}), 256'(2'b01));
    end
    out_ready = 1'b1; #1;
    chk("bp_drain_ready", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_busy_next", 256'(busy), 256'(1));
    plast = pv;
    wait_ov(cyc);
    chk("bp_chain_lat", 256'(cyc), 256'(2));
    chk("bp_chain", 256'(p), 256'(77000 + 143));
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    plast = 213'(77000 + 143);

    // reset mid-operation
    a = 149'd7; b = 64'd9; in_acc = 0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mrst_busy", 256'(busy), 256'(0));
    chk("mrst_out_valid", 256'(out_valid), 256'(0));
    chk("mrst_in_ready", 256'(in_ready), 256'(1));
    chk("mrst_p", 256'(p), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    plast = '0; plast3 = '0;
    do_op("post_rst", 149'd1, 64'd1, 1'b1);

    // NDIG=3 variant: single op then a back-to-back stream
    v_a = 20'hFFFFF; v_b = 48'hFFFF_0000_FFFF; v_in_acc = 0; v_in_valid = 1'b1;
    @(posedge clk); #1; v_in_valid = 1'b0;
    cyc = 0;
    while (!v_out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("v_lat", 256'(cyc), 256'(3));
    chk("v_max", 256'(v_p), 256'(68'hFFFFF * 68'hFFFF_0000_FFFF));
    plast3 = 68'hFFFFF * 68'hFFFF_0000_FFFF;
    v_out_ready = 1'b1; @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      sa[i] = 20'($urandom); sb[i] = {16'($urandom), 32'($urandom)}; sc[i] = 1'($urandom_range(0, 1));
      exp3[i] = {48'b0, sa[i]} * {20'b0, sb[i]} + (sc[i] ? ((i == 0) ? plast3 : exp3[i-1]) : 68'd0);
    end
    v_a = sa[0]; v_b = sb[0]; v_in_acc = sc[0]; v_in_valid = 1'b1;
    @(posedge clk); #1;
    di = 1; v_a = sa[1]; v_b = sb[1]; v_in_acc = sc[1];
    r = 0; cyc = 0; last_cyc = 0; prev_ov = 1'b0;
    while (r < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (prev_ov) begin
        di++;
        if (di < 4) begin v_a = sa[di]; v_b = sb[di]; v_in_acc = sc[di]; end
        else v_in_valid = 1'b0;
      end
      prev_ov = v_out_valid;
      if (v_out_valid) begin
        chk("v_stream", 256'(v_p), 256'(exp3[r]));
        if (r > 0) chk("v_period", 256'(cyc - last_cyc), 256'(4));
        last_cyc = cyc;
        r++;
      end
    end
    chk("v_stream_count", 256'(r), 256'(4));
    @(posedge clk); #1;
    chk("v_idle", 256'({v_busy, v_out_valid, v_in_ready}), 256'(3'b001));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mult_wide_iter.md
# mult_wide_iter

Parametrised, digit-serial wide multiplier. It computes `p = a * b`, or `p = a * b + previous result` in accumulate mode, by splitting `b` into `DIGIT_W`-bit digits. It adds one shifted `A_W x DIGIT_W` partial product per cycle into a full-width accumulator. It succeeds the fixed 149x64 two-slice multiplier in the modular-arithmetic datapath: it trades latency for area, adds valid/ready handshakes and back-pressure, and allows multiply-accumulate chaining.

## Interface
Parameters:
- `A_W`, default 149: width of operand `a`.
- `B_W`, default 64: width of operand `b`. Must be an integer multiple of `DIGIT_W`; any other value is an elaboration error.
- `DIGIT_W`, default 32: digit width processed per cycle.
- Derived, not overridable:
  - `NDIG = B_W/DIGIT_W`.
  - `P_W = A_W + B_W`.
  - `CNT_W = max(1, clog2(NDIG))`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: operand request.
- `in_ready`, out, 1: block can accept operands.
- `a`, in, `A_W`: multiplicand, unsigned.
- `b`, in, `B_W`: multiplier, unsigned.
- `in_acc`, in, 1: when 1, the result is `a*b + p_last`.
- `out_valid`, out, 1: result available on `p`.
- `out_ready`, in, 1: consumer takes the result.
- `p`, out, `P_W`: result, unsigned, modulo `2^P_W`.
- `busy`, out, 1: high in BUSY state.

## Operation
States:
- IDLE: `in_ready=1`, `out_valid=0`.
- BUSY: digit iteration. `in_ready=0`, `out_valid=0`, `busy=1`.
- DONE: `out_valid=1`. `in_ready=out_ready`, which allows accept-on-drain.

Transitions:
- IDLE → BUSY on `in_valid && in_ready`.
- BUSY → DONE when digit counter `k == NDIG-1` at that edge.
- DONE → IDLE on `out_ready && !in_valid`.
- DONE → BUSY on `out_ready && in_valid`: the result is consumed and new operands are taken on the same edge.
- DONE holds while `out_ready=0`.

Accept edge:
- Register `a` and `b`.
- Set `k=0`.
- Set `acc = in_acc ? p_last : 0`. `p_last` is the last result delivered to the output.

BUSY edge for digit `k`, LSB digit first:
- `acc <= acc + ((a_r * b_r[k*DIGIT_W +: DIGIT_W]) << (k*DIGIT_W))`, truncated to `P_W` bits.
- Increment `k`.

Entry to DONE:
- `p` is driven from `acc`.
- `p_last` updates to `acc` at the edge where the output handshake (`out_valid && out_ready`) completes.

Arithmetic:
- All unsigned.
- With `in_acc=0` the result is exact, because the product fits in `P_W`.
- With `in_acc=1` the sum wraps modulo `2^P_W`; there is no overflow flag.

Other rules:
- `in_valid` while `in_ready=0` is ignored. The requester must hold its request until accepted.
- `out_ready` outside DONE is ignored.
- `p` holds its last value in IDLE and BUSY, and is stable throughout DONE.
- `a`, `b` and `in_acc` are sampled only at the accept edge; later changes have no effect.
- `NDIG=1` is legal: BUSY lasts exactly one cycle.

## Timing
- Latency: accept edge `t`; digits are processed at edges `t+1 … t+NDIG`; `out_valid=1` from edge `t+NDIG`. Default parameters give 2 cycles.
- Throughput with `out_ready` tied high: one result per `NDIG+1` cycles.
- Combinational paths:
  - `out_ready` → `in_ready` in DONE.
  - No input → `out_valid` path.
- Reset while `rst_n=0`, at any time including mid-BUSY or DONE:
  - State goes to IDLE.
  - `out_valid=0`, `busy=0`, `in_ready=1`.
  - `p=0`, `p_last=0`, `acc=0`, `k=0`.
  - An in-flight operation is discarded.
- First rising edge after `rst_n` deasserts may accept an operand.

## Test plan
- **Basic:** `a=1`, `b=2^64-1`, `in_acc=0`.
  - `out_valid` rises exactly 2 cycles after accept.
  - `p=2^64-1`.
- **Maximum operands:** `a=2^149-1`, `b=2^64-1`.
  - `p=2^213-2^149-2^64+1`.
- **Accumulate:** `(a=3, b=5, in_acc=0)` gives `p=15`. Then `(a=2, b=4, in_acc=1)` gives `p=23`. Then `(a=0, b=0, in_acc=1)` gives `p=23`.
- **Back-pressure:**
  - Hold `out_ready=0` for 5 cycles in DONE: `p` stays stable, `in_ready=0`, and a pending `in_valid` is not taken.
  - Then raise `out_ready` with `in_valid=1`: the next operation is accepted on the same edge and `busy=1` the next cycle.
- **Reset:**
  - Assert `rst_n=0` mid-BUSY, one cycle after accept of `a=7`, `b=9`: outputs go to reset values immediately.
  - After release, `(a=1, b=1, in_acc=1)` gives `p=1`, confirming `p_last` was cleared.
- **Parameter variant:** `A_W=20`, `B_W=48`, `DIGIT_W=16`, so `NDIG=3`.
  - `a=2^20-1`, `b=0xFFFF_0000_FFFF`: latency 3 cycles, `p=(2^20-1)*0xFFFF0000FFFF`.
  - Back-to-back stream of 4 operations: throughput is one result per 4 cycles.
